// File: rtl/instr_encoder_loader.sv
// rtl/instr_encoder_loader.sv - encodes decoded instruction fields into 32-bit ARM words and writes them to instruction RAM
//
// Purpose:
//   Inverse of the decode stage. Each accepted field beat is encoded into one
//   ARM word and written to consecutive instruction-RAM addresses starting at
//   base_addr_i. One write per accepted beat, one cycle after acceptance.
//
// Ports:
//   clk_i, rst_i        clock (rising edge), asynchronous active-high reset
//   start_i, base_addr_i begin a session at base_addr_i (ignored while running)
//   in_valid_i/in_ready_o/in_last_i  field-beat handshake, in_last_i ends session
//   cond_i .. imm24_i   decoded instruction fields
//   wr_en_o, wr_addr_o, wr_data_o    instruction-RAM write port
//   busy_o              session running
//   done_o              one-cycle pulse with the session's final write
//   err_illegal_o       sticky: an unmapped opcode was written as HALT this session
//   err_ovf_o           sticky: address space ran out before in_last_i

module instr_encoder_loader #(
  parameter int ADDR_W = 7
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic              in_last_i,
  input  logic [3:0]        cond_i,
  input  logic [6:0]        opcode_i,
  input  logic              en_status_i,
  input  logic [3:0]        rn_i,
  input  logic [3:0]        rd_i,
  input  logic [3:0]        rs_i,
  input  logic [3:0]        rm_i,
  input  logic [1:0]        shift_op_i,
  input  logic [4:0]        imm5_i,
  input  logic [11:0]       imm12_i,
  input  logic [23:0]       imm24_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [31:0]       wr_data_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_illegal_o,
  output logic              err_ovf_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [31:0]       wr_data_q;
  logic              done_q;
  logic              err_illegal_q;
  logic              err_ovf_q;

  logic [31:0] word_d;
  logic        illegal_d;
  logic [3:0]  op4;
  logic        dp_ok;
  logic        ls_reg;
  logic        ls_load;
  logic [3:0]  ls_rn;
  logic [11:0] ls_off;

  // Combinational encoder; anything unmapped falls back to the HALT word.
  always_comb begin
    word_d    = {cond_i, 8'h10, 20'h0};
    illegal_d = 1'b0;
    dp_ok     = 1'b1;
    case (opcode_i[2:0])
      3'b000:  op4 = 4'b0100;
      3'b001:  op4 = 4'b0010;
      3'b010:  op4 = 4'b1010;
      3'b011:  op4 = 4'b0000;
      3'b100:  op4 = 4'b1100;
      3'b101:  op4 = 4'b0001;
      default: begin
        op4   = 4'b0000;
        dp_ok = 1'b0;
      end
    endcase

    // Load/store: opcode is {kind, P, U, W}; literal loads force rn to the PC.
    ls_reg  = (opcode_i[6:3] == 4'b1100) || (opcode_i[6:3] == 4'b1110);
    ls_load = (opcode_i[6:3] == 4'b1101) || (opcode_i[6:3] == 4'b1001) ||
              (opcode_i[6:3] == 4'b1100);
    ls_rn   = (opcode_i[6:3] == 4'b1001) ? 4'hF : rn_i;
    ls_off  = ls_reg ? {imm5_i, shift_op_i, 1'b0, rm_i} : imm12_i;

    case (opcode_i[6:3])
      4'b0000: begin
        if (opcode_i[2:0] == 3'b000)
          word_d = {cond_i, 3'b001, 4'b1101, en_status_i, rn_i, rd_i, imm12_i};
        else if (opcode_i[2:0] != 3'b001)
          illegal_d = 1'b1;
      end
      4'b0001: begin
        if (dp_ok) word_d = {cond_i, 3'b001, op4, en_status_i, rn_i, rd_i, imm12_i};
        else       illegal_d = 1'b1;
      end
      4'b0010: begin
        if (opcode_i[2:0] == 3'b000)
          word_d = {cond_i, 3'b000, 4'b1101, en_status_i, rn_i, rd_i,
                    imm5_i, shift_op_i, 1'b0, rm_i};
        else
          illegal_d = 1'b1;
      end
      4'b0011: begin
        if (dp_ok) word_d = {cond_i, 3'b000, op4, en_status_i, rn_i, rd_i,
                             imm5_i, shift_op_i, 1'b0, rm_i};
        else       illegal_d = 1'b1;
      end
      4'b0110: begin
        if (opcode_i[2:0] == 3'b000)
          word_d = {cond_i, 3'b000, 4'b1101, en_status_i, rn_i, rd_i,
                    rs_i, 1'b0, shift_op_i, 1'b1, rm_i};
        else
          illegal_d = 1'b1;
      end
      4'b0111: begin
        if (dp_ok) word_d = {cond_i, 3'b000, op4, en_status_i, rn_i, rd_i,
                             rs_i, 1'b0, shift_op_i, 1'b1, rm_i};
        else       illegal_d = 1'b1;
      end
      4'b1000: begin
        case (opcode_i[2:0])
          3'b000:  word_d = {cond_i, 4'b1010, imm24_i};
          3'b100:  word_d = {cond_i, 4'b1011, imm24_i};
          3'b001:  word_d = {cond_i, 8'b0001_0010, 12'hFFF, 4'b0001, rm_i};
          3'b101:  word_d = {cond_i, 8'b0001_0010, 12'hFFF, 4'b0011, rm_i};
          default: illegal_d = 1'b1;
        endcase
      end
      4'b1001, 4'b1100, 4'b1101, 4'b1110, 4'b1111: begin
        word_d = {cond_i, 2'b01, ls_reg, opcode_i[2], opcode_i[1], 1'b0,
                  opcode_i[0], ls_load, ls_rn, rd_i, ls_off};
      end
      default: illegal_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      done_q        <= 1'b0;
      err_illegal_q <= 1'b0;
      err_ovf_q     <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            state_q       <= S_RUN;
            addr_q        <= base_addr_i;
            err_illegal_q <= 1'b0;
            err_ovf_q     <= 1'b0;
          end
        end
        S_RUN: begin
          if (in_valid_i) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= addr_q;
            wr_data_q <= word_d;
            if (illegal_d) err_illegal_q <= 1'b1;
            // Last address used without in_last: close the session rather than wrap.
            if (in_last_i || (addr_q == ADDR_LAST)) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              if (!in_last_i) err_ovf_q <= 1'b1;
            end
            if (addr_q != ADDR_LAST) addr_q <= addr_q + ADDR_ONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready_o    = (state_q == S_RUN);
  assign busy_o        = (state_q == S_RUN);
  assign wr_en_o       = wr_en_q;
  assign wr_addr_o     = wr_addr_q;
  assign wr_data_o     = wr_data_q;
  assign done_o        = done_q;
  assign err_illegal_o = err_illegal_q;
  assign err_ovf_o     = err_ovf_q;

endmodule
